// File: rtl/spike_isi_monitor.sv
`default_nettype none
// ============================================================================
// Module      : spike_isi_monitor
// Description : Edge-detects the neuron core's spike level, measures
//               inter-spike intervals in clock cycles, and queues them in a
//               first-word-fall-through FIFO with a valid/ready read port.
//               Also reports a windowed spike rate and a burst flag.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_isi_monitor #(
  parameter int ISI_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int WINDOW     = 1024,
  parameter int BURST_ISI  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spike_in,
  input  logic             en,
  input  logic             isi_ready,
  output logic             isi_valid,
  output logic [ISI_W-1:0] isi_data,
  output logic [7:0]       rate,
  output logic             rate_valid,
  output logic             burst,
  output logic             fifo_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WIN_W = $clog2(WINDOW);

  localparam logic [ISI_W-1:0] ISI_MAX   = '1;
  localparam logic [ISI_W:0]   BURST_LIM = (ISI_W+1)'(BURST_ISI);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  logic             s1_q, s2_q;
  state_t           state_q, state_d;
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
  logic             burst_q, burst_d;
  logic             push;

  logic [ISI_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  logic [WIN_W-1:0] win_cnt_q;
  logic [7:0]       spk_cnt_q;
  logic [7:0]       rate_q;
  logic             rate_valid_q;

  logic             spike_event;
  logic [ISI_W:0]   cnt_inc;
  logic [ISI_W-1:0] isi_sat;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_wr;
  logic [7:0]       spk_next;

  // Rising edge of the sampled spike level, only while the monitor is enabled
  assign spike_event = s1_q & ~s2_q & en;

  // isi_cnt+1 doubles as the measured interval and the saturating increment
  assign cnt_inc = {1'b0, isi_cnt_q} + (ISI_W+1)'(1);
  assign isi_sat = cnt_inc[ISI_W] ? ISI_MAX : cnt_inc[ISI_W-1:0];

  // Two-flop sampler of the spike level for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= spike_in;
      s2_q <= s1_q;
    end
  end

  // IDLE/TRACK state, interval counter and burst flag registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      isi_cnt_q <= '0;
      burst_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      isi_cnt_q <= isi_cnt_d;
      burst_q   <= burst_d;
    end
  end

  // Next state: the first event only arms tracking; later events emit an ISI.
  // Burst clears as soon as the interval in progress can no longer end within
  // BURST_ISI cycles, i.e. when the post-increment count plus one exceeds it.
  always_comb begin
    state_d   = state_q;
    isi_cnt_d = isi_cnt_q;
    burst_d   = burst_q;
    push      = 1'b0;
    if (!en) begin
      state_d   = IDLE;
      isi_cnt_d = '0;
      burst_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          isi_cnt_d = '0;
          if (spike_event) begin
            state_d = TRACK;
          end
        end
        TRACK: begin
          if (spike_event) begin
            push      = 1'b1;
            isi_cnt_d = '0;
            burst_d   = ({1'b0, isi_sat} <= BURST_LIM);
          end else begin
            isi_cnt_d = isi_sat;
            if (cnt_inc >= BURST_LIM) begin
              burst_d = 1'b0;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          isi_cnt_d = '0;
        end
      endcase
    end
  end

  // A push into a full FIFO is accepted only when a pop frees the head slot
  assign fifo_pop  = (count_q != '0) & isi_ready;
  assign fifo_full = (count_q == FULL_CNT);
  assign fifo_wr   = push & (~fifo_full | fifo_pop);

  // FIFO storage; contents need no reset since the count gates visibility
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= isi_sat;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (fifo_wr && !fifo_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!fifo_wr && fifo_pop) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (push && !fifo_wr) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Saturating spike count including this cycle's event
  assign spk_next = (spike_event && (spk_cnt_q != 8'hFF)) ? spk_cnt_q + 8'd1 : spk_cnt_q;

  // Rate window: counters freeze while disabled, result latched at window end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win_cnt_q    <= '0;
      spk_cnt_q    <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
    end else begin
      rate_valid_q <= 1'b0;
      if (en) begin
        if (win_cnt_q == WIN_LAST) begin
          win_cnt_q    <= '0;
          rate_q       <= spk_next;
          rate_valid_q <= 1'b1;
          spk_cnt_q    <= '0;
        end else begin
          win_cnt_q <= win_cnt_q + WIN_W'(1);
          spk_cnt_q <= spk_next;
        end
      end
    end
  end

  assign isi_valid     = (count_q != '0);
  assign isi_data      = isi_valid ? mem_q[rd_ptr_q] : '0;
  assign rate          = rate_q;
  assign rate_valid    = rate_valid_q;
  assign burst         = burst_q;
  assign fifo_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_isi_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_isi_monitor
// Description : Directed table-driven bench for spike_isi_monitor with
//               hand-written sequences for the multi-cycle corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_isi_monitor;

  logic       clk;
  logic       reset_n;
  logic       spike_in;
  logic       en;
  logic       isi_ready;
  logic       isi_valid;
  logic [7:0] isi_data;
  logic [7:0] rate;
  logic       rate_valid;
  logic       burst;
  logic       fifo_overflow;

  int checks;
  int errors;

  // One table row: hold the inputs for n cycles, then compare the outputs
  typedef struct {
    int         n;
    logic       sp;
    logic       en;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       eb;
    logic       eo;
  } vec_t;

  spike_isi_monitor #(
    .ISI_W     (8),
    .FIFO_DEPTH(4),
    .WINDOW    (16),
    .BURST_ISI (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spike_in     (spike_in),
    .en           (en),
    .isi_ready    (isi_ready),
    .isi_valid    (isi_valid),
    .isi_data     (isi_data),
    .rate         (rate),
    .rate_valid   (rate_valid),
    .burst        (burst),
    .fifo_overflow(fifo_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive spike_in for one cycle; outputs are sampled 1 time unit after the edge
  task automatic tick(input logic sp);
    spike_in = sp;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset_n   = 1'b0;
    spike_in  = 1'b0;
    en        = 1'b1;
    isi_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk({tag, " rst valid"},      32'(isi_valid),     32'd0);
    chk({tag, " rst data"},       32'(isi_data),      32'd0);
    chk({tag, " rst rate"},       32'(rate),          32'd0);
    chk({tag, " rst rate_valid"}, 32'(rate_valid),    32'd0);
    chk({tag, " rst burst"},      32'(burst),         32'd0);
    chk({tag, " rst overflow"},   32'(fifo_overflow), 32'd0);
  endtask

  task automatic run_table(input vec_t v[$], input string tag);
    foreach (v[i]) begin
      en        = v[i].en;
      isi_ready = v[i].rdy;
      repeat (v[i].n) tick(v[i].sp);
      chk($sformatf("%s[%0d] valid", tag, i),    32'(isi_valid),     32'(v[i].ev));
      chk($sformatf("%s[%0d] data", tag, i),     32'(isi_data),      32'(v[i].ed));
      chk($sformatf("%s[%0d] burst", tag, i),    32'(burst),         32'(v[i].eb));
      chk($sformatf("%s[%0d] overflow", tag, i), 32'(fifo_overflow), 32'(v[i].eo));
    end
  endtask

  initial begin
    vec_t       t1[$];
    vec_t       t2[$];
    logic [7:0] exp3 [4];
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    spike_in  = 1'b0;
    en        = 1'b1;
    isi_ready = 1'b0;

    // Held spike gives one event; second event 10 cycles later pushes 10
    t1.push_back('{10, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0});
    t1.push_back('{3,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0});
    t1.push_back('{7,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0});
    t1.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0});
    t1.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b1, 8'd10, 1'b0, 1'b0});
    t1.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b1, 8'd10, 1'b0, 1'b0});
    t1.push_back('{1,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0});
    t1.push_back('{5,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0});

    // Six spikes 3 cycles apart with no reader: fill, overflow, burst
    t2.push_back('{2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
    t2.push_back('{1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
    t2.push_back('{2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
    t2.push_back('{1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
    t2.push_back('{1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0});
    t2.push_back('{1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0});
    t2.push_back('{1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0});
    t2.push_back('{2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0});
    t2.push_back('{1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0});
    t2.push_back('{2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0});
    t2.push_back('{1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0});
    t2.push_back('{2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0});
    t2.push_back('{1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0});
    t2.push_back('{3, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b1});
    t2.push_back('{1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b1});
    t2.push_back('{1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 1'b1});
    t2.push_back('{1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 1'b1});
    t2.push_back('{2, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 1'b1});
    t2.push_back('{1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1});
    t2.push_back('{2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1});

    exp3[0] = 8'd6;
    exp3[1] = 8'd7;
    exp3[2] = 8'd8;
    exp3[3] = 8'd9;

    do_reset("t1");
    run_table(t1, "t1");

    do_reset("t2");
    run_table(t2, "t2");

    // Full FIFO with simultaneous push and pop keeps four entries in order
    do_reset("t3");
    tick(1'b1);
    for (int g = 5; g <= 8; g++) begin
      repeat (g - 1) tick(1'b0);
      tick(1'b1);
    end
    tick(1'b0);
    chk("t3 full valid", 32'(isi_valid), 32'd1);
    chk("t3 full head",  32'(isi_data),  32'd5);
    repeat (7) tick(1'b0);
    tick(1'b1);
    isi_ready = 1'b1;
    tick(1'b0);
    chk("t3 pushpop overflow", 32'(fifo_overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3 pop%0d valid", i), 32'(isi_valid), 32'd1);
      chk($sformatf("t3 pop%0d data", i),  32'(isi_data),  32'(exp3[i]));
      tick(1'b0);
    end
    chk("t3 drained valid", 32'(isi_valid),     32'd0);
    chk("t3 end overflow",  32'(fifo_overflow), 32'd0);
    isi_ready = 1'b0;

    // Window of 16: events at win_cnt 0, 7 and 15 of the second window
    do_reset("t4");
    for (int c = 0; c < 48; c++) begin
      tick((c == 15) || (c == 22) || (c == 30));
      if (c == 15) begin
        chk("t4 w0 rate_valid", 32'(rate_valid), 32'd1);
        chk("t4 w0 rate",       32'(rate),       32'd0);
      end
      if (c == 30) chk("t4 pre-wrap rate_valid", 32'(rate_valid), 32'd0);
      if (c == 31) begin
        chk("t4 w1 rate_valid", 32'(rate_valid), 32'd1);
        chk("t4 w1 rate",       32'(rate),       32'd3);
      end
      if (c == 32) begin
        chk("t4 pulse width", 32'(rate_valid), 32'd0);
        chk("t4 rate hold",   32'(rate),       32'd3);
      end
      if (c == 47) begin
        chk("t4 w2 rate_valid", 32'(rate_valid), 32'd1);
        chk("t4 w2 rate",       32'(rate),       32'd0);
      end
    end

    // Long silence saturates the interval at 255
    do_reset("t5");
    tick(1'b1);
    tick(1'b0);
    repeat (299) tick(1'b0);
    chk("t5 pre valid", 32'(isi_valid), 32'd0);
    tick(1'b1);
    tick(1'b0);
    chk("t5 sat valid", 32'(isi_valid), 32'd1);
    chk("t5 sat data",  32'(isi_data),  32'd255);
    chk("t5 burst",     32'(burst),     32'd0);

    // Disable between spikes: FIFO readable, first event after re-enable rearms
    do_reset("t6");
    tick(1'b1);
    tick(1'b0);
    repeat (3) tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    chk("t6 first isi", 32'(isi_data), 32'd5);
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    chk("t6 burst set", 32'(burst), 32'd1);
    en = 1'b0;
    tick(1'b0);
    chk("t6 en0 burst", 32'(burst),     32'd0);
    chk("t6 en0 valid", 32'(isi_valid), 32'd1);
    chk("t6 en0 head",  32'(isi_data),  32'd5);
    isi_ready = 1'b1;
    tick(1'b0);
    isi_ready = 1'b0;
    repeat (3) tick(1'b0);
    chk("t6 en0 pop valid", 32'(isi_valid), 32'd1);
    chk("t6 en0 pop head",  32'(isi_data),  32'd3);
    en = 1'b1;
    tick(1'b1);
    tick(1'b0);
    repeat (3) tick(1'b0);
    chk("t6 rearm no push",  32'(isi_data), 32'd3);
    isi_ready = 1'b1;
    tick(1'b0);
    isi_ready = 1'b0;
    chk("t6 rearm empty", 32'(isi_valid), 32'd0);
    tick(1'b1);
    tick(1'b0);
    chk("t6 track valid", 32'(isi_valid),     32'd1);
    chk("t6 track isi",   32'(isi_data),      32'd6);
    chk("t6 overflow",    32'(fifo_overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
